// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for the clb36 logic block.
// Hunts a preamble, shifts in a frame and commits it on a good ones-count checksum.
module clb_cfg_loader #(
    parameter int          CFG_W = 37,
    parameter logic [7:0]  PRE   = 8'hA5
) (
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DEN,
    input  logic             PROG,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [CFG_W-1:0] CFG_RST  = CFG_W'(37'h0_380A_8116);
    localparam logic [5:0]       LAST_BIT = 6'(CFG_W - 1);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        SUM,
        CHECK
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       window;
    logic [7:0]       win_n;
    logic [CFG_W-1:0] shadow;
    logic [5:0]       cnt;
    logic [5:0]       ones;
    logic [7:0]       csum;
    logic             sum_ok;

    assign win_n  = {window[6:0], DIN};
    assign sum_ok = ({2'b00, ones} == csum);
    assign BUSY   = (state != HUNT);

    always_ff @(posedge K) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            HUNT: begin
                if (DEN && win_n == PRE) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (DEN && cnt == LAST_BIT) begin
                    state_n = SUM;
                end
            end
            SUM: begin
                if (DEN && cnt == 6'd7) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                state_n = HUNT;
            end
            default: begin
                state_n = HUNT;
            end
        endcase
        if (PROG) begin
            state_n = HUNT;
        end
    end

    always_ff @(posedge K) begin
        if (RST) begin
            window    <= '0;
            shadow    <= '0;
            cnt       <= '0;
            ones      <= '0;
            csum      <= '0;
            CFG       <= CFG_RST;
            CFG_VALID <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            CFG_VALID <= 1'b0;
            if (PROG) begin
                // Abort wipes the frame in flight but keeps the committed config.
                window <= '0;
                shadow <= '0;
                cnt    <= '0;
                ones   <= '0;
                csum   <= '0;
                DONE   <= 1'b0;
                ERR    <= 1'b0;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (DEN) begin
                            window <= win_n;
                            if (win_n == PRE) begin
                                shadow <= '0;
                                cnt    <= '0;
                                ones   <= '0;
                                csum   <= '0;
                                DONE   <= 1'b0;
                                ERR    <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (DEN) begin
                            shadow <= {shadow[CFG_W-2:0], DIN};
                            ones   <= ones + 6'(DIN);
                            cnt    <= (cnt == LAST_BIT) ? 6'd0 : cnt + 6'd1;
                        end
                    end
                    SUM: begin
                        if (DEN) begin
                            csum <= {csum[6:0], DIN};
                            cnt  <= cnt + 6'd1;
                        end
                    end
                    CHECK: begin
                        window <= '0;
                        cnt    <= '0;
                        if (sum_ok) begin
                            CFG       <= shadow;
                            CFG_VALID <= 1'b1;
                            DONE      <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                    default: begin
                        window <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: vector table, corner sequences
// and random frames checked against a frame-level reference model.
module tb_clb_cfg_loader;

    localparam logic [36:0] CFG_RST = 37'h0_380A_8116;

    logic        K = 1'b0;
    logic        RST;
    logic        DIN;
    logic        DEN;
    logic        PROG;
    logic [36:0] CFG;
    logic        CFG_VALID;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_cfg;

    clb_cfg_loader dut (
        .K        (K),
        .RST      (RST),
        .DIN      (DIN),
        .DEN      (DEN),
        .PROG     (PROG),
        .CFG      (CFG),
        .CFG_VALID(CFG_VALID),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 K = ~K;

    typedef struct {
        logic [36:0] d;
        logic [7:0]  s;
        logic [36:0] e_cfg;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled at the same point.
    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (g) begin
            DEN = 1'b0;
            DIN = 1'($urandom_range(0, 1));
            @(posedge K);
            #1;
        end
        DEN = 1'b1;
        DIN = b;
        @(posedge K);
        #1;
        DEN = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], max_gap);
        end
    endtask

    task automatic send_frame(input logic [36:0] d, input logic [7:0] s,
                              input int max_gap, input logic [36:0] e_cfg,
                              input logic e_done, input logic e_err);
        logic [36:0] cfg_before;
        cfg_before = CFG;
        send_byte(8'hA5, max_gap);
        chk("busy_after_pre", 64'(BUSY), 64'd1);
        for (int i = 36; i >= 0; i--) begin
            send_bit(d[i], max_gap);
        end
        send_byte(s, max_gap);
        chk("busy_in_check", 64'(BUSY), 64'd1);
        chk("cfg_hold_in_check", 64'(CFG), 64'(cfg_before));
        @(posedge K);
        #1;
        chk("cfg_valid_pulse", 64'(CFG_VALID), 64'(e_done));
        chk("cfg", 64'(CFG), 64'(e_cfg));
        chk("done", 64'(DONE), 64'(e_done));
        chk("err", 64'(ERR), 64'(e_err));
        chk("busy_after", 64'(BUSY), 64'd0);
        @(posedge K);
        #1;
        chk("cfg_valid_fall", 64'(CFG_VALID), 64'd0);
    endtask

    initial begin
        RST  = 1'b1;
        DEN  = 1'b0;
        DIN  = 1'b0;
        PROG = 1'b0;
        exp_cfg = CFG_RST;

        vecs[0] = '{37'h1_0000_00FF, 8'h09, 37'h1_0000_00FF, 1'b1, 1'b0};
        vecs[1] = '{37'h1_0000_00FF, 8'h08, 37'h1_0000_00FF, 1'b0, 1'b1};
        vecs[2] = '{37'h0_380A_8116, 8'h0A, 37'h0_380A_8116, 1'b1, 1'b0};
        vecs[3] = '{37'h1F_FFFF_FFFF, 8'h25, 37'h1F_FFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{37'h0, 8'h00, 37'h0, 1'b1, 1'b0};
        vecs[5] = '{37'h0, 8'h40, 37'h0, 1'b0, 1'b1};
        vecs[6] = '{37'h0_00A5_A500, 8'h08, 37'h0_00A5_A500, 1'b1, 1'b0};

        repeat (2) @(posedge K);
        #1;
        RST = 1'b0;
        chk("rst_cfg", 64'(CFG), 64'(CFG_RST));
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_valid", 64'(CFG_VALID), 64'd0);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].s, 0, vecs[i].e_cfg,
                       vecs[i].e_done, vecs[i].e_err);
        end

        // Gapped DEN must give the same result as a dense frame.
        send_frame(37'h1_0000_00FF, 8'h09, 3, 37'h1_0000_00FF, 1'b1, 1'b0);
        exp_cfg = 37'h1_0000_00FF;

        // Abort partway through the config bits.
        send_byte(8'hA5, 0);
        for (int i = 36; i >= 17; i--) begin
            send_bit(1'b1, 0);
        end
        chk("prog_busy_before", 64'(BUSY), 64'd1);
        PROG = 1'b1;
        DEN  = 1'b1;
        DIN  = 1'b1;
        @(posedge K);
        #1;
        PROG = 1'b0;
        DEN  = 1'b0;
        chk("prog_busy", 64'(BUSY), 64'd0);
        chk("prog_done", 64'(DONE), 64'd0);
        chk("prog_err", 64'(ERR), 64'd0);
        chk("prog_cfg", 64'(CFG), 64'(exp_cfg));
        send_frame(CFG_RST, 8'h0A, 0, CFG_RST, 1'b1, 1'b0);

        // Reset during the checksum field, then re-hunt.
        send_frame(37'h1_0000_00FF, 8'h09, 0, 37'h1_0000_00FF, 1'b1, 1'b0);
        send_byte(8'hA5, 0);
        for (int i = 36; i >= 0; i--) begin
            send_bit(1'b0, 0);
        end
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        RST = 1'b1;
        @(posedge K);
        #1;
        RST = 1'b0;
        chk("rst_sum_cfg", 64'(CFG), 64'(CFG_RST));
        chk("rst_sum_busy", 64'(BUSY), 64'd0);
        chk("rst_sum_done", 64'(DONE), 64'd0);
        chk("rst_sum_valid", 64'(CFG_VALID), 64'd0);
        send_byte(8'h00, 0);
        send_frame(37'h0_00A5_A500, 8'h08, 1, 37'h0_00A5_A500, 1'b1, 1'b0);
        exp_cfg = 37'h0_00A5_A500;

        // Random frames against a frame-level model.
        for (int n = 0; n < 40; n++) begin
            logic [36:0] d;
            logic [7:0]  s;
            logic [7:0]  ones;
            logic        ok;
            d    = 37'({$urandom(), $urandom()});
            ones = 8'($countones(d));
            if ($urandom_range(0, 3) == 0) begin
                s = ones + 8'($urandom_range(1, 200));
            end else begin
                s = ones;
            end
            ok = (s == ones);
            if (ok) begin
                exp_cfg = d;
            end
            repeat ($urandom_range(0, 2)) send_bit(1'b0, 1);
            send_frame(d, s, $urandom_range(0, 3), exp_cfg, ok, !ok);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
